ad9970_lvds_tx: RTL and testbench
=================================

Name: ad9970_lvds_tx

Overview:
- Synthesizable 2-lane serializer producing the AD9970-style LVDS word stream: forwarded clock pattern, per-line sync-word burst, blanking window and right/left-aligned 14-bit pixels.
- It is the transmit end of the link consumed by the CCD deserializer. It is used as an RTL stimulus source in the ccd_deser bench and as the loopback generator in board self-test.
- Runs on the bit clock. One 16-bit word (8 bits per lane) is sent every 8 clocks, MSB first.

Parameters:
- DATA_WD, 14, pixel width.
- WORD_WD, 16, serial word width (8 bits per lane).
- LOC_WD, 13, line-position counter width.
- SYNC_NUM, 7, number of sync words per line.

Ports:
- clk  in  1  bit clock
- reset  in  1  asynchronous, active-high
- i_enable  in  1  transmit enable, level
- i_hd  in  1  line start, synchronous to clk; rising edge is significant
- iv_pix_data  in  DATA_WD  pixel, sampled when o_pix_req=1
- i_align_right  in  1  1: word={2'b00,pix}; 0: word={pix,2'b00}
- iv_sync_start_loc  in  LOC_WD  word position of the first sync word
- iv_sync_word  in  SYNC_NUM*WORD_WD  sync words, word k at [16k+15:16k]
- iv_hblk_tog1  in  LOC_WD  blank start position (inclusive)
- iv_hblk_tog2  in  LOC_WD  blank end position (exclusive)
- o_pix_req  out  1  one-clock pixel request
- o_tck  out  1  forwarded clock pattern
- ov_dout  out  2  lane data; [0] carries word[15:8], [1] carries word[7:0]
- o_word_start  out  1  high with bit 0 of each word

Behaviour:
- Reset values: all outputs 0; bit_cnt=0; pos=0; state=IDLE; shadow registers 0.
- Framing:
  - bit_cnt (3 bit) free-runs 0..7 from reset release and is never realigned by HD.
  - o_tck is registered: 1 while bit_cnt is 0..3, 0 while bit_cnt is 4..7.
  - o_word_start=1 exactly when bit_cnt=0.
- Word load:
  - At the edge ending bit_cnt=7, shift registers sh0/sh1 (8 bit) load the selected word.
  - ov_dout={sh1[7],sh0[7]}; shift left once per clock.
  - Bit 7 of each lane is on ov_dout during bit_cnt=0.
- HD detection: hd_d registered; hd_rise=i_hd&~hd_d.
- State machine:
  - IDLE → LINE on hd_rise while i_enable=1.
  - LINE → IDLE when i_enable=0, sampled at a word load only, so the current word always completes.
  - Reset mid-word forces IDLE immediately and sets ov_dout=0.
- Shadow registers: sync_start_loc, sync words, hblk_tog1/2 and align_right are captured on hd_rise. Mid-line input changes have no effect.
- Position counter:
  - hd_rise arms a pending flag; the next word load uses pos=0.
  - pos increments on every later load and saturates at 2^LOC_WD-1.
  - hd_rise in the same cycle as a load: that load is pos=0.
- Word selection per load, priority order:
  - IDLE: 0x0000.
  - Sync: pos in [sync_start_loc, sync_start_loc+SYNC_NUM-1] → sync word k=pos-sync_start_loc. Window addition uses LOC_WD+1 bits; the part beyond the saturation limit is not sent.
  - Blank: tog1<=pos<tog2 → 0x0000. tog2<=tog1 means no blanking.
  - Otherwise: the aligned pixel.
- Pixel handshake:
  - o_pix_req=1 during bit_cnt=7 only when the upcoming load selects a pixel.
  - iv_pix_data is sampled at that edge. Latency is 1 clock from sample to first bit on ov_dout.
- A new hd_rise during a sync burst aborts the burst; the next word is pos=0.
- i_hd held high produces no further rise.

Decomposition:
- Shared include/package ad9970_tx_def:
  - BIT_PER_LANE=8
  - SYNC_NUM
  - BLANK_WORD=16'h0000
  - state encodings IDLE/LINE
  - default sync word 16'h8421
- One natural sub-module, ad9970_lane_ser: an 8-bit load/shift register. Instantiate it twice.

Test Plan:
- Reset release, i_enable=0 → o_tck toggles 4 high/4 low; ov_dout=0; o_pix_req never asserted.
- Enable, hd_rise, sync_start_loc=124, all sync words 16'h8421, tog1=0, tog2=137:
  - positions 0..123 → word 0x0000, no request;
  - positions 124..130 → lane0 0x84, lane1 0x21;
  - positions 131..136 → 0x0000;
  - position 137 → first o_pix_req.
- Pixel 14'h3ABC with align_right=1 → word 16'h3ABC; lanes 0x3A/0xBC, MSB on o_word_start cycle. With align_right=0 → 16'hEAF0.
- hd_rise at sync word index 3 → burst aborted; next word is pos 0 (0x0000 when blank covers 0). Change sync_start_loc mid-line → no effect until the next hd_rise.
- i_enable dropped at bit_cnt=3 of a pixel word → that word completes; following words are 0x0000. Reset asserted at bit_cnt=5 → ov_dout=0 and o_pix_req=0 immediately.
- tog1=10, tog2=10 → no blanking. sync_start_loc=8190 → only words 0..1 sent, then pos saturates at 8191 and pixels continue.

Source files
------------

// File: rtl/ad9970_tx_def.sv
`default_nettype none
// ad9970_tx_def: shared constants and state encoding for the AD9970 LVDS transmitter.
// Revision 1.0

package ad9970_tx_def;
  localparam int          BIT_PER_LANE      = 8;
  localparam int          SYNC_NUM          = 7;
  localparam logic [15:0] BLANK_WORD        = 16'h0000;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h8421;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LINE = 1'b1
  } tx_state_t;
endpackage

`default_nettype wire

// File: rtl/ad9970_lvds_tx_if.sv
`default_nettype none
// ad9970_lvds_tx_if: line-control, pixel handshake and serial outputs of the transmitter.
// Revision 1.0

interface ad9970_lvds_tx_if #(
  parameter int DATA_WD  = 14,
  parameter int WORD_WD  = 16,
  parameter int LOC_WD   = 13,
  parameter int SYNC_NUM = 7
);
  logic                        i_enable;
  logic                        i_hd;
  logic [DATA_WD-1:0]          iv_pix_data;
  logic                        i_align_right;
  logic [LOC_WD-1:0]           iv_sync_start_loc;
  logic [SYNC_NUM*WORD_WD-1:0] iv_sync_word;
  logic [LOC_WD-1:0]           iv_hblk_tog1;
  logic [LOC_WD-1:0]           iv_hblk_tog2;
  logic                        o_pix_req;
  logic                        o_tck;
  logic [1:0]                  ov_dout;
  logic                        o_word_start;

  modport master (
    output i_enable, i_hd, iv_pix_data, i_align_right, iv_sync_start_loc,
           iv_sync_word, iv_hblk_tog1, iv_hblk_tog2,
    input  o_pix_req, o_tck, ov_dout, o_word_start
  );

  modport slave (
    input  i_enable, i_hd, iv_pix_data, i_align_right, iv_sync_start_loc,
           iv_sync_word, iv_hblk_tog1, iv_hblk_tog2,
    output o_pix_req, o_tck, ov_dout, o_word_start
  );
endinterface

`default_nettype wire

// File: rtl/ad9970_lane_ser.sv
`default_nettype none
// ad9970_lane_ser: one LVDS lane, parallel load then MSB-first shift.
// Revision 1.0

module ad9970_lane_ser
  import ad9970_tx_def::*;
#(
  parameter int WIDTH = BIT_PER_LANE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else begin
      sh <= {sh[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sh[WIDTH-1];
endmodule

`default_nettype wire

// File: rtl/ad9970_lvds_tx.sv
`default_nettype none
// ad9970_lvds_tx: 2-lane AD9970-style word serializer (sync burst, blanking, pixels).
// Revision 1.0

module ad9970_lvds_tx #(
  parameter int DATA_WD  = 14,
  parameter int WORD_WD  = 16,
  parameter int LOC_WD   = 13,
  parameter int SYNC_NUM = 7
) (
  input  logic            clk,
  input  logic            reset,
  ad9970_lvds_tx_if.slave tx
);
  import ad9970_tx_def::tx_state_t;
  import ad9970_tx_def::IDLE;
  import ad9970_tx_def::LINE;
  import ad9970_tx_def::BLANK_WORD;

  localparam int                LANE_WD = WORD_WD / 2;
  localparam int                PAD_WD  = WORD_WD - DATA_WD;
  localparam logic [LOC_WD-1:0] POS_MAX = '1;

  tx_state_t                   state;
  logic [2:0]                  bit_cnt;
  logic                        hd_d;
  logic                        pend;
  logic [LOC_WD-1:0]           pos;
  logic                        tck;
  logic                        word_start;
  logic [LOC_WD-1:0]           sync_start_loc;
  logic [LOC_WD-1:0]           hblk_tog1;
  logic [LOC_WD-1:0]           hblk_tog2;
  logic [SYNC_NUM*WORD_WD-1:0] sync_word;
  logic                        align_right;

  logic                        hd_rise;
  logic                        load;
  logic [2:0]                  bit_nxt;
  logic                        restart;
  logic                        load_sat;
  logic [LOC_WD-1:0]           load_pos;
  logic [LOC_WD-1:0]           cur_ssl;
  logic [LOC_WD-1:0]           cur_tog1;
  logic [LOC_WD-1:0]           cur_tog2;
  logic [SYNC_NUM*WORD_WD-1:0] cur_sync;
  logic                        cur_align;
  logic [LOC_WD:0]             sync_end;
  logic [LOC_WD-1:0]           sync_diff;
  logic                        active;
  logic                        in_sync;
  logic                        in_blank;
  logic                        sel_pix;
  logic [WORD_WD-1:0]          sync_sel;
  logic [WORD_WD-1:0]          pix_word;
  logic [WORD_WD-1:0]          word;
  logic                        lane0_bit;
  logic                        lane1_bit;

  assign hd_rise = tx.i_hd & ~hd_d;
  assign load    = (bit_cnt == 3'd7);
  assign bit_nxt = bit_cnt + 3'd1;

  // An HD rise coincident with a load already governs that load.
  assign cur_ssl   = hd_rise ? tx.iv_sync_start_loc : sync_start_loc;
  assign cur_tog1  = hd_rise ? tx.iv_hblk_tog1      : hblk_tog1;
  assign cur_tog2  = hd_rise ? tx.iv_hblk_tog2      : hblk_tog2;
  assign cur_sync  = hd_rise ? tx.iv_sync_word      : sync_word;
  assign cur_align = hd_rise ? tx.i_align_right     : align_right;

  assign restart  = hd_rise | pend;
  assign load_sat = ~restart & (pos == POS_MAX);

  always_comb begin
    load_pos = pos + 1'b1;
    if (restart) begin
      load_pos = '0;
    end else if (load_sat) begin
      load_pos = pos;
    end
  end

  // Repeats at the saturation limit never re-enter the sync window.
  assign sync_end  = {1'b0, cur_ssl} + (LOC_WD + 1)'(SYNC_NUM - 1);
  assign sync_diff = load_pos - cur_ssl;
  assign in_sync   = ~load_sat & (load_pos >= cur_ssl) & ({1'b0, load_pos} <= sync_end);
  assign in_blank  = (cur_tog2 > cur_tog1) & (load_pos >= cur_tog1) & (load_pos < cur_tog2);
  assign active    = tx.i_enable & ((state == LINE) | hd_rise);
  assign sel_pix   = active & ~in_sync & ~in_blank;

  always_comb begin
    sync_sel = WORD_WD'(BLANK_WORD);
    for (int k = 0; k < SYNC_NUM; k++) begin
      if (sync_diff == LOC_WD'(k)) begin
        sync_sel = cur_sync[k*WORD_WD +: WORD_WD];
      end
    end
  end

  assign pix_word = cur_align ? {{PAD_WD{1'b0}}, tx.iv_pix_data}
                              : {tx.iv_pix_data, {PAD_WD{1'b0}}};

  always_comb begin
    word = WORD_WD'(BLANK_WORD);
    if (active) begin
      if (in_sync) begin
        word = sync_sel;
      end else if (!in_blank) begin
        word = pix_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      hd_d           <= 1'b0;
      pend           <= 1'b0;
      pos            <= '0;
      tck            <= 1'b0;
      word_start     <= 1'b0;
      sync_start_loc <= '0;
      hblk_tog1      <= '0;
      hblk_tog2      <= '0;
      sync_word      <= '0;
      align_right    <= 1'b0;
    end else begin
      bit_cnt    <= bit_nxt;
      tck        <= ~bit_nxt[2];
      word_start <= (bit_nxt == 3'd0);
      hd_d       <= tx.i_hd;

      if (hd_rise) begin
        sync_start_loc <= tx.iv_sync_start_loc;
        hblk_tog1      <= tx.iv_hblk_tog1;
        hblk_tog2      <= tx.iv_hblk_tog2;
        sync_word      <= tx.iv_sync_word;
        align_right    <= tx.i_align_right;
      end

      if (hd_rise && tx.i_enable) begin
        state <= LINE;
      end else if (load && !tx.i_enable) begin
        state <= IDLE;
      end

      if (load) begin
        pos  <= load_pos;
        pend <= 1'b0;
      end else if (hd_rise) begin
        pend <= 1'b1;
      end
    end
  end

  ad9970_lane_ser #(.WIDTH(LANE_WD)) u_lane0 (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (word[WORD_WD-1 -: LANE_WD]),
    .msb   (lane0_bit)
  );

  ad9970_lane_ser #(.WIDTH(LANE_WD)) u_lane1 (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (word[LANE_WD-1:0]),
    .msb   (lane1_bit)
  );

  assign tx.ov_dout      = {lane1_bit, lane0_bit};
  assign tx.o_pix_req    = load & sel_pix;
  assign tx.o_tck        = tck;
  assign tx.o_word_start = word_start;
endmodule

`default_nettype wire

// File: tb/tb_ad9970_lvds_tx.sv
`default_nettype none
// tb_ad9970_lvds_tx: randomized line stimulus checked against a word-level model of the link.
// Revision 1.0

module tb_ad9970_lvds_tx;
  localparam int POS_LIMIT = 8191;

  logic clk;
  logic reset;

  ad9970_lvds_tx_if tx ();

  ad9970_lvds_tx dut (
    .clk   (clk),
    .reset (reset),
    .tx    (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk, n_pass, n_fail;
  bit pix_fixed;

  // Model state: what a line should look like, tracked per word slot.
  int          m_phase, m_cyc, m_pos;
  bit          m_hd_prev, m_line, m_pend, m_sat, m_align;
  int          m_ssl, m_t1, m_t2;
  logic [15:0] m_sync [7];
  logic [15:0] exp_q [$];
  logic [7:0]  c0, c1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_run();
    bit          rise, active, sync_hit, blank_hit, want_pix;
    logic [15:0] expw;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_phase = 0; m_cyc = 0; m_pos = 0;
        m_hd_prev = 0; m_line = 0; m_pend = 0; m_sat = 0; m_align = 0;
        m_ssl = 0; m_t1 = 0; m_t2 = 0;
        foreach (m_sync[k]) m_sync[k] = 16'h0;
        exp_q.delete();
        exp_q.push_back(16'h0);
        c0 = 8'h0; c1 = 8'h0;
      end else begin
        rise = tx.i_hd && !m_hd_prev;
        c0 = {c0[6:0], tx.ov_dout[0]};
        c1 = {c1[6:0], tx.ov_dout[1]};
        if (m_cyc >= 8) begin
          check_eq("tck", 32'(tx.o_tck), 32'(m_phase < 4));
          check_eq("word_start", 32'(tx.o_word_start), 32'(m_phase == 0));
        end
        if (rise) begin
          m_ssl   = int'(tx.iv_sync_start_loc);
          m_t1    = int'(tx.iv_hblk_tog1);
          m_t2    = int'(tx.iv_hblk_tog2);
          m_align = tx.i_align_right;
          foreach (m_sync[k]) m_sync[k] = tx.iv_sync_word[16*k +: 16];
        end
        if (m_phase == 7) begin
          if (exp_q.size() > 0) check_eq("word", 32'({c0, c1}), 32'(exp_q.pop_front()));
          if (rise || m_pend) begin
            m_pos = 0;
            m_sat = 0;
          end else if (m_pos == POS_LIMIT) begin
            m_sat = 1;
          end else begin
            m_pos++;
          end
          active    = tx.i_enable && (m_line || rise);
          sync_hit  = !m_sat && (m_pos >= m_ssl) && (m_pos < m_ssl + 7);
          blank_hit = (m_t2 > m_t1) && (m_pos >= m_t1) && (m_pos < m_t2);
          want_pix  = active && !sync_hit && !blank_hit;
          if (!active || (!sync_hit && blank_hit)) expw = 16'h0;
          else if (sync_hit)                       expw = m_sync[m_pos - m_ssl];
          else if (m_align)                        expw = 16'(int'(tx.iv_pix_data));
          else                                     expw = 16'(int'(tx.iv_pix_data) * 4);
          check_eq("pix_req", 32'(tx.o_pix_req), 32'(want_pix));
          exp_q.push_back(expw);
          m_pend = 0;
        end else begin
          if (rise) m_pend = 1;
          check_eq("pix_req_off", 32'(tx.o_pix_req), 32'h0);
        end
        if (rise && tx.i_enable)             m_line = 1;
        else if (m_phase == 7 && !tx.i_enable) m_line = 0;
        m_hd_prev = tx.i_hd;
        m_phase   = (m_phase + 1) % 8;
        m_cyc++;
      end
    end
  endtask

  task automatic pix_run();
    forever begin
      @(posedge clk);
      #1;
      tx.iv_pix_data = pix_fixed ? 14'h3ABC : 14'($urandom);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_phase != p && n < 16);
    if (m_phase != p) check_eq("wait_phase_timeout", 32'(m_phase), 32'(p));
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n = 0;
    while (m_pos != target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_pos != target) check_eq("wait_pos_timeout", 32'(m_pos), 32'(target));
  endtask

  task automatic start_line(input int ssl, input logic [111:0] syncs, input int t1,
                            input int t2, input bit align, input int hold);
    tx.iv_sync_start_loc = 13'(ssl);
    tx.iv_sync_word      = syncs;
    tx.iv_hblk_tog1      = 13'(t1);
    tx.iv_hblk_tog2      = 13'(t2);
    tx.i_align_right     = align;
    tx.i_hd              = 1'b1;
    cycles(hold);
    tx.i_hd              = 1'b0;
  endtask

  function automatic logic [111:0] rand_syncs();
    logic [111:0] s;
    for (int k = 0; k < 7; k++) s[16*k +: 16] = 16'($urandom);
    return s;
  endfunction

  logic [111:0] all_8421;

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    pix_fixed = 1'b1;
    reset = 1'b1;
    tx.i_enable = 1'b0; tx.i_hd = 1'b0; tx.i_align_right = 1'b0;
    tx.iv_pix_data = '0; tx.iv_sync_start_loc = '0; tx.iv_sync_word = '0;
    tx.iv_hblk_tog1 = '0; tx.iv_hblk_tog2 = '0;
    for (int k = 0; k < 7; k++) all_8421[16*k +: 16] = 16'h8421;
    fork
      model_run();
      pix_run();
    join_none

    cycles(4);
    reset = 1'b0;
    cycles(40);
    start_line(2, all_8421, 0, 1, 1, 2);
    cycles(40);

    tx.i_enable = 1'b1;
    cycles($urandom_range(0, 7));
    start_line(124, all_8421, 0, 137, 1, 2);
    wait_pos(150, 4000);

    cycles($urandom_range(0, 7));
    start_line(4, rand_syncs(), 0, 2, 0, 3);
    wait_pos(6, 400);
    tx.iv_sync_start_loc = 13'd20;
    tx.iv_hblk_tog2 = 13'd30;
    wait_pos(25, 400);

    pix_fixed = 1'b0;
    start_line(5, rand_syncs(), 0, 3, 1, 1);
    wait_pos(8, 400);
    cycles($urandom_range(0, 7));
    start_line(5, rand_syncs(), 0, 3, 0, 2);
    wait_pos(20, 400);

    wait_phase(3);
    tx.i_enable = 1'b0;
    cycles(40);
    tx.i_enable = 1'b1;
    cycles(24);
    start_line(3, rand_syncs(), 12, 4, 1, 1);
    wait_pos(12, 400);

    wait_phase(5);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_dout", 32'(tx.ov_dout), 32'h0);
    check_eq("rst_pix_req", 32'(tx.o_pix_req), 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(20);

    for (int i = 0; i < 4; i++) begin
      cycles($urandom_range(0, 7));
      start_line($urandom_range(0, 40), rand_syncs(), $urandom_range(0, 50),
                 $urandom_range(0, 50), 1'($urandom), $urandom_range(1, 30));
      cycles(8 * $urandom_range(20, 45));
      if ($urandom_range(0, 3) == 0) begin
        tx.i_enable = 1'b0;
        cycles($urandom_range(5, 30));
        tx.i_enable = 1'b1;
      end
      cycles($urandom_range(0, 40));
    end

    start_line(8190, all_8421, 10, 10, 1, 2);
    wait_pos(POS_LIMIT, 70000);
    cycles(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
